// File: rtl/vga_timing_rx_if.sv
// Sync inputs and recovered-timing outputs of the VGA timing receiver.
// The video source (or bench) is the master; the receiver is the slave.
interface vga_timing_rx_if;
   logic        HS;
   logic        VS;
   logic [9:0]  rxHor;
   logic [9:0]  rxVer;
   logic        rxActive;
   logic        locked;
   logic        errPulse;
   logic [10:0] lastLinePeriod;
   logic [9:0]  lastFrameLines;

   modport master (
      output HS, VS,
      input  rxHor, rxVer, rxActive, locked, errPulse, lastLinePeriod, lastFrameLines
   );

   modport slave (
      input  HS, VS,
      output rxHor, rxVer, rxActive, locked, errPulse, lastLinePeriod, lastFrameLines
   );
endinterface

// File: rtl/vga_timing_rx.sv
// Rebuilds pixel coordinates from HS/VS edges, measures line/pulse/frame timing
// against the configured mode and reports lock and timing violations.
module vga_timing_rx #(
   parameter int HOR_SIZE = 800,
   parameter int HOR_AL   = 640,
   parameter int HOR_FP   = 16,
   parameter int HOR_PW   = 96,
   parameter int VER_SIZE = 521,
   parameter int VER_AF   = 480,
   parameter int VER_FP   = 10,
   parameter int VER_PW   = 2,
   parameter int TIMEOUT  = 1600
) (
   input  logic           ckVideo,
   input  logic           reset,
   vga_timing_rx_if.slave bus
);

   if (HOR_AL + HOR_FP + HOR_PW > HOR_SIZE || VER_AF + VER_FP + VER_PW > VER_SIZE) begin : g_bad_cfg
      $error("vga_timing_rx: sync pulse does not fit inside the line/frame");
   end

   localparam logic [9:0]  HOR_SYNC = 10'(HOR_AL + HOR_FP);
   localparam logic [9:0]  HOR_LAST = 10'(HOR_SIZE - 1);
   localparam logic [9:0]  HOR_ACT  = 10'(HOR_AL);
   localparam logic [9:0]  VER_SYNC = 10'(VER_AF + VER_FP);
   localparam logic [9:0]  VER_LAST = 10'(VER_SIZE - 1);
   localparam logic [9:0]  VER_ACT  = 10'(VER_AF);
   localparam logic [10:0] LINE_LEN = 11'(HOR_SIZE);
   localparam logic [10:0] PW_LEN   = 11'(HOR_PW);
   localparam logic [9:0]  FRM_LEN  = 10'(VER_SIZE);
   localparam logic [10:0] TMO      = 11'(TIMEOUT);

   typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

   logic        r_sHS, r_sHS_d, r_sVS, r_sVS_d;
   logic [9:0]  r_hor, r_ver;
   logic        r_vsPend, r_hsSeen, r_frmBad;
   logic [10:0] r_lineCnt, r_pwCnt, r_lastLine;
   logic [9:0]  r_frmCnt, r_lastFrm;
   logic        r_locked, r_err;
   state_t      r_state, w_next;

   logic w_hsFall, w_vsFall, w_vsTake, w_lineChk, w_lineBad, w_frmOk, w_timeout;
   logic w_lockNxt, w_errNxt;

   assign w_hsFall  = r_sHS_d & ~r_sHS;
   assign w_vsFall  = r_sVS_d & ~r_sVS;
   // A VS fall is consumed by the next HS fall (or the same-cycle one).
   assign w_vsTake  = w_hsFall & (r_vsPend | w_vsFall);
   assign w_lineChk = w_hsFall & r_hsSeen;
   assign w_lineBad = w_lineChk & ((r_lineCnt != LINE_LEN) | (r_pwCnt != PW_LEN));
   assign w_frmOk   = (r_frmCnt == FRM_LEN) & ~r_frmBad & ~w_lineBad;
   assign w_timeout = (r_lineCnt == TMO);

   always_ff @(posedge ckVideo or posedge reset) begin
      if (reset) begin
         r_sHS      <= 1'b1;
         r_sHS_d    <= 1'b1;
         r_sVS      <= 1'b1;
         r_sVS_d    <= 1'b1;
         r_hor      <= '0;
         r_ver      <= '0;
         r_vsPend   <= 1'b0;
         r_hsSeen   <= 1'b0;
         r_frmBad   <= 1'b0;
         r_lineCnt  <= '0;
         r_pwCnt    <= '0;
         r_lastLine <= '0;
         r_frmCnt   <= '0;
         r_lastFrm  <= '0;
      end else begin
         r_sHS   <= bus.HS;
         r_sHS_d <= r_sHS;
         r_sVS   <= bus.VS;
         r_sVS_d <= r_sVS;

         if (w_hsFall)               r_hor <= HOR_SYNC;
         else if (r_hor >= HOR_LAST) r_hor <= '0;
         else                        r_hor <= r_hor + 10'd1;

         if (w_vsTake)               r_ver <= VER_SYNC;
         else if (w_hsFall)          r_ver <= (r_ver >= VER_LAST) ? '0 : r_ver + 10'd1;

         if (w_vsTake)               r_vsPend <= 1'b0;
         else if (w_vsFall)          r_vsPend <= 1'b1;

         if (w_hsFall)               r_lineCnt <= 11'd1;
         else if (r_lineCnt != '1)   r_lineCnt <= r_lineCnt + 11'd1;
         if (w_lineChk)              r_lastLine <= r_lineCnt;

         if (w_hsFall)                       r_pwCnt <= 11'd1;
         else if (~r_sHS && r_pwCnt != '1)   r_pwCnt <= r_pwCnt + 11'd1;

         // After a timeout the next HS fall has no meaningful period, same as after reset.
         if (w_timeout)              r_hsSeen <= 1'b0;
         else if (w_hsFall)          r_hsSeen <= 1'b1;

         if (w_vsTake)                       r_frmCnt <= 10'd1;
         else if (w_hsFall && r_frmCnt != '1) r_frmCnt <= r_frmCnt + 10'd1;
         if (w_vsTake)               r_lastFrm <= r_frmCnt;

         if (w_vsTake)               r_frmBad <= 1'b0;
         else if (w_lineBad)         r_frmBad <= 1'b1;
      end
   end

   always_ff @(posedge ckVideo or posedge reset) begin
      if (reset) begin
         r_state  <= SEARCH;
         r_locked <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_locked <= w_lockNxt;
         r_err    <= w_errNxt;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         SEARCH:  if (w_vsTake) w_next = MEASURE;
         MEASURE: if (w_vsTake && w_frmOk) w_next = LOCKED;
         LOCKED:  if (w_lineBad || (w_vsTake && !w_frmOk)) w_next = SEARCH;
         default: w_next = SEARCH;
      endcase
      if (w_timeout) w_next = SEARCH;
   end

   always_comb begin
      w_lockNxt = (w_next == LOCKED);
      w_errNxt  = (r_state == LOCKED) && (w_next != LOCKED);
   end

   assign bus.rxHor          = r_hor;
   assign bus.rxVer          = r_ver;
   assign bus.rxActive       = r_locked && (r_hor < HOR_ACT) && (r_ver < VER_ACT);
   assign bus.locked         = r_locked;
   assign bus.errPulse       = r_err;
   assign bus.lastLinePeriod = r_lastLine;
   assign bus.lastFrameLines = r_lastFrm;

endmodule
